// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_e             : controller FSM states (RUN/WAIT/ERROR = 0/1/2)
//   REG_ADDR_W, reg_addr_t, REG_ZERO : register address width, type and x0
//   MEM_TIMEOUT_DEFAULT : default watchdog limit in consecutive wait cycles
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = '0;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StWait  = 2'd1,
    StError = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives stage status, receives hold/bubble commands
//   slave  : controller side
// Status : id_valid, id_rs1/2, id_uses_rs1/2, exe_valid, exe_rd, exe_is_load,
//          exe_branch_taken, mem_req, mem_ready
// Command: pc_stall, ifid_stall, idexe_stall, exemem_stall, ifid_flush, idexe_flush
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic      id_valid;
  reg_addr_t id_rs1;
  reg_addr_t id_rs2;
  logic      id_uses_rs1;
  logic      id_uses_rs2;
  logic      exe_valid;
  reg_addr_t exe_rd;
  logic      exe_is_load;
  logic      exe_branch_taken;
  logic      mem_req;
  logic      mem_ready;

  logic      pc_stall;
  logic      ifid_stall;
  logic      idexe_stall;
  logic      exemem_stall;
  logic      ifid_flush;
  logic      idexe_flush;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output exe_valid, exe_rd, exe_is_load, exe_branch_taken, mem_req, mem_ready,
    input  pc_stall, ifid_stall, idexe_stall, exemem_stall, ifid_flush, idexe_flush
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  exe_valid, exe_rd, exe_is_load, exe_branch_taken, mem_req, mem_ready,
    output pc_stall, ifid_stall, idexe_stall, exemem_stall, ifid_flush, idexe_flush
  );

endinterface

// File: rtl/pipe_hazard_ctrl_perf_counter.sv
// Saturating event counter: counts cycles with i_inc high, sticks at all-ones.
//   i_clk   : clock
//   i_clr   : synchronous clear (highest priority)
//   i_inc   : count this cycle
//   o_count : current count
module pipe_hazard_ctrl_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage core.
// Produces same-cycle hold/bubble commands for PC, IF/ID, ID/EXE and EXE/MEM,
// watches data-memory wait time, and counts stall/flush cycles.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   bus (slave)     : stage status in, stall/flush commands out
//   o_state         : FSM state (0 RUN, 1 WAIT, 2 ERROR)
//   o_mem_timeout   : sticky watchdog error flag
//   o_stall_cnt     : saturating count of pc_stall cycles
//   o_flush_cnt     : saturating count of cycles with any flush
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  pipe_hazard_ctrl_if.slave  bus,
  output logic [1:0]         o_state,
  output logic               o_mem_timeout,
  output logic [CNT_W-1:0]   o_stall_cnt,
  output logic [CNT_W-1:0]   o_flush_cnt
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  state_e           r_state, w_state_d;
  logic [WaitW-1:0] r_wait_cnt, w_wait_d, w_wait_inc;
  logic             r_mem_timeout, w_timeout_d;

  logic w_mem_stuck, w_frz, w_rs1_hit, w_rs2_hit, w_lu;
  logic w_pc_stall, w_ifid_stall, w_idexe_stall, w_exemem_stall;
  logic w_ifid_flush, w_idexe_flush;

  // Hazard detection; x0 is hardwired so it never carries a dependency.
  assign w_rs1_hit = bus.id_uses_rs1 & (bus.id_rs1 == bus.exe_rd);
  assign w_rs2_hit = bus.id_uses_rs2 & (bus.id_rs2 == bus.exe_rd);
  assign w_lu      = bus.id_valid & bus.exe_valid & bus.exe_is_load &
                     (bus.exe_rd != REG_ZERO) & (w_rs1_hit | w_rs2_hit);

  assign w_mem_stuck = bus.mem_req & ~bus.mem_ready;
  assign w_frz       = w_mem_stuck | (r_state == StError);

  assign w_wait_inc = r_wait_cnt + WaitW'(1);

  // Watchdog FSM next state.
  always_comb begin
    w_state_d   = r_state;
    w_wait_d    = r_wait_cnt;
    w_timeout_d = r_mem_timeout;
    unique case (r_state)
      StRun: begin
        if (w_mem_stuck) begin
          w_wait_d = WaitW'(1);
          if (MEM_TIMEOUT <= 1) begin
            w_state_d   = StError;
            w_timeout_d = 1'b1;
          end else begin
            w_state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!w_mem_stuck) begin
          w_state_d = StRun;
          w_wait_d  = '0;
        end else begin
          // This cycle is wait number r_wait_cnt+1; trip on reaching the limit.
          w_wait_d = w_wait_inc;
          if (w_wait_inc == WaitW'(MEM_TIMEOUT)) begin
            w_state_d   = StError;
            w_timeout_d = 1'b1;
          end
        end
      end
      StError: begin
      end
      default: begin
        w_state_d = StRun;
        w_wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StRun;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_wait_cnt    <= w_wait_d;
      r_mem_timeout <= w_timeout_d;
    end
  end

  // Command generation. Reset bubbles everything; a freeze outranks a taken
  // branch so the branch is flushed on the first unfrozen cycle.
  always_comb begin
    w_pc_stall     = 1'b0;
    w_ifid_stall   = 1'b0;
    w_idexe_stall  = 1'b0;
    w_exemem_stall = 1'b0;
    w_ifid_flush   = 1'b0;
    w_idexe_flush  = 1'b0;
    if (i_rst) begin
      w_ifid_flush  = 1'b1;
      w_idexe_flush = 1'b1;
    end else if (w_frz) begin
      w_pc_stall     = 1'b1;
      w_ifid_stall   = 1'b1;
      w_idexe_stall  = 1'b1;
      w_exemem_stall = 1'b1;
    end else if (bus.exe_branch_taken) begin
      w_ifid_flush  = 1'b1;
      w_idexe_flush = 1'b1;
    end else if (w_lu) begin
      w_pc_stall    = 1'b1;
      w_ifid_stall  = 1'b1;
      w_idexe_flush = 1'b1;
    end
  end

  assign bus.pc_stall     = w_pc_stall;
  assign bus.ifid_stall   = w_ifid_stall;
  assign bus.idexe_stall  = w_idexe_stall;
  assign bus.exemem_stall = w_exemem_stall;
  assign bus.ifid_flush   = w_ifid_flush;
  assign bus.idexe_flush  = w_idexe_flush;

  pipe_hazard_ctrl_perf_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_inc   (w_pc_stall),
    .o_count (o_stall_cnt)
  );

  pipe_hazard_ctrl_perf_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_inc   (w_ifid_flush | w_idexe_flush),
    .o_count (o_flush_cnt)
  );

  assign o_state       = r_state;
  assign o_mem_timeout = r_mem_timeout;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RISC-V core. Generates per-cycle stall (hold) and flush (bubble) commands for the PC, IF/ID, ID/EXE and EXE/MEM registers from ID-stage operand usage, EXE-stage load/branch status and the data-memory handshake. Tracks memory wait time with a watchdog and keeps saturating stall/flush performance counters. Sits beside the pipeline registers in the core top level; every pipeline register takes its hold/clear from this block.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum consecutive wait cycles on a data-memory access before the error state.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  5 each  ID source register addresses.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads that operand.
- exe_valid  in  1  EXE stage holds a real instruction.
- exe_rd  in  5  EXE destination register.
- exe_is_load  in  1  EXE instruction is a load (result selected from memory).
- exe_branch_taken  in  1  branch/jump resolved taken in EXE this cycle.
- mem_req  in  1  MEM stage is issuing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_stall, ifid_stall, idexe_stall, exemem_stall  out  1 each  hold the register.
- ifid_flush, idexe_flush  out  1 each  load a bubble (all control fields zero).
- state_o  out  2  current FSM state encoding.
- mem_timeout  out  1  sticky error flag.
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters.

## Operation
- Load-use hazard (lu): id_valid & exe_valid & exe_is_load & exe_rd != 0 & ((id_uses_rs1 & id_rs1 == exe_rd) | (id_uses_rs2 & id_rs2 == exe_rd)). Register x0 never creates a hazard.
- Freeze (frz): (mem_req & ~mem_ready) | state == ERROR.
- Command priority, highest first:
  - frz: all four stalls = 1; both flushes = 0.
  - exe_branch_taken: ifid_flush = idexe_flush = 1; all stalls = 0; lu is ignored.
  - lu: pc_stall = ifid_stall = 1, idexe_flush = 1; idexe_stall = exemem_stall = 0.
  - Otherwise all outputs = 0.
- Branch and lu in the same cycle: flush only, no stall.
- A branch held in EXE during a freeze is flushed on the first unfrozen cycle, i.e. the cycle mem_ready rises.
- FSM states, encodings 0/1/2:
  - RUN: goes to WAIT when mem_req & ~mem_ready; wait_cnt is set to 1.
  - WAIT: goes to RUN when mem_ready or ~mem_req. Otherwise wait_cnt increments; when wait_cnt == MEM_TIMEOUT with mem_ready still low, goes to ERROR and sets mem_timeout.
  - ERROR: terminal. Freezes the pipeline until rst.
- Counters:
  - stall_cnt increments on every cycle with pc_stall = 1.
  - flush_cnt increments on every cycle with ifid_flush | idexe_flush.
  - Both saturate at all-ones. They never wrap.

## Timing
- All stall/flush outputs are combinational (Mealy) from the current inputs and state, valid in the same cycle. There is no added latency.
- state_o, mem_timeout and counters are registered; each updates one cycle after its cause.
- Reset (rst = 1 at an edge), including mid-wait or in ERROR: state = RUN, wait_cnt = 0, mem_timeout = 0, counters = 0.
- While rst is asserted, all stalls = 0 and both flushes = 1, so the pipeline clears.
- A load-use stall lasts exactly one cycle. The bubble makes exe_valid = 0 in the next cycle, and forwarding from WB covers the operand.
- The timeout fires on the edge ending the MEM_TIMEOUT-th consecutive wait cycle. If mem_ready arrives in that same cycle, the access completes and state returns to RUN.

## Structure
- Shared package (Types.v): state encodings RUN/WAIT/ERROR, `regAddr width, REG_ZERO constant, default MEM_TIMEOUT.
- One sub-module, pipe_perf_counter: a saturating CNT_W counter with inc/clr, instantiated twice.
- Hazard compare logic stays inline.

## Test plan
- Load-use: exe_is_load=1, exe_rd=5, id_rs2=5, id_uses_rs2=1 -> pc_stall=ifid_stall=idexe_flush=1 for one cycle only; stall_cnt = 1 afterwards.
- x0 / unused operand: exe_rd=0 with id_rs1=0, then exe_rd=7 with id_rs1=7 and id_uses_rs1=0 -> no stall or flush in either case.
- Branch plus load-use together: exe_branch_taken=1 with the lu condition true -> ifid_flush=idexe_flush=1, pc_stall=0; flush_cnt increments by 1.
- Memory wait then branch: mem_req=1, mem_ready=0 for 3 cycles with exe_branch_taken=1 -> all stalls = 1 and flushes = 0 for those 3 cycles. State_o shows WAIT from the 2nd cycle. On the cycle mem_ready=1, the flushes assert and the stalls drop.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> ERROR after 4 wait cycles, mem_timeout=1, permanent freeze. rst for one cycle -> RUN, flag and counters = 0.
- Saturation: CNT_W=3 with 10 consecutive lu stalls -> stall_cnt holds at 7.
